// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding and operand-width bounds for the bit-serial subtractor.
//   Exports state_e (IDLE/RUN/DONE) and the legal WIDTH range.
package serial_sub_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_sub_full_sub.sv
// full_sub: one-bit full subtractor cell.
//   x, y, bi : minuend bit, subtrahend bit, borrow-in
//   d, bo    : difference bit, borrow-out
module full_sub (
   output logic d,
   output logic bo,
   input  logic x,
   input  logic y,
   input  logic bi
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, diff = a - b - b_in, LSB first, one bit per clock.
//   clk, rst_n          : clock, async active-low reset
//   start, a, b, b_in   : request and operands, captured when accepted in IDLE or DONE
//   busy, done          : high during RUN / one-cycle result-valid pulse
//   diff, b_out, zero, ovf : result and flags, held until the next completion
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             zero,
   output logic             ovf
);
   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_sub: WIDTH out of range");
   end
   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
   logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
   logic             d_bit, bo_bit;
   full_sub u_cell (
      .d  (d_bit),
      .bo (bo_bit),
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .bi (br_q)
   );
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      if (state_q == RUN) begin
         // result bits enter at the MSB so after WIDTH shifts bit 0 is at position 0
         res_d = {d_bit, res_q[WIDTH-1:1]};
         sa_d  = sa_q >> 1;
         sb_d  = sb_q >> 1;
         br_d  = bo_bit;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            diff_d  = res_d;
            bout_d  = bo_bit;
            zero_d  = (res_d == '0);
            ovf_d   = (amsb_q != bmsb_q) && (res_d[WIDTH-1] != amsb_q);
         end
      end else if (start) begin
         state_d = RUN;
         sa_d    = a;
         sb_d    = b;
         br_d    = b_in;
         cnt_d   = '0;
         res_d   = '0;
         amsb_d  = a[WIDTH-1];
         bmsb_d  = b[WIDTH-1];
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign diff  = diff_q;
   assign b_out = bout_q;
   assign zero  = zero_q;
   assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and random checks of serial_sub against an arithmetic reference model.
module tb_serial_sub;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n, start, b_in;
   logic [W-1:0] a, b;
   logic         busy, done, b_out, zero, ovf;
   logic [W-1:0] diff;
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           last_done = 0;
   int           gap = 0;
   logic [W-1:0] p_diff;
   logic         p_bout, p_zero, p_ovf;
   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out),
      .zero  (zero),
      .ovf   (ovf)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_diff"}, 32'(diff), 0);
      chk({tag, "_bout"}, 32'(b_out), 0);
      chk({tag, "_zero"}, 32'(zero), 0);
      chk({tag, "_ovf"}, 32'(ovf), 0);
   endtask
   // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge of the DONE cycle,
   // or one cycle later when idle is set.
   task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                     input bit mid, input bit idle);
      int           d;
      logic [W-1:0] ed;
      a = ai;
      b = bi;
      b_in = ci;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      b_in = 1'($urandom);
      d = int'(ai) - int'(bi) - int'(ci);
      ed = W'(d);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         chk("run_busy", 32'(busy), 1);
         chk("run_done", 32'(done), 0);
         chk("run_diff_held", 32'(diff), 32'(p_diff));
         chk("run_bout_held", 32'(b_out), 32'(p_bout));
         chk("run_zero_held", 32'(zero), 32'(p_zero));
         chk("run_ovf_held", 32'(ovf), 32'(p_ovf));
         if (mid) begin
            start = (i == 3);
            a = W'($urandom);
            b = W'($urandom);
         end
      end
      start = 1'b0;
      @(negedge clk);
      gap = cyc - last_done;
      last_done = cyc;
      p_diff = ed;
      p_bout = (d < 0);
      p_zero = (ed == '0);
      p_ovf = (ai[W-1] != bi[W-1]) && (ed[W-1] != ai[W-1]);
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("diff", 32'(diff), 32'(p_diff));
      chk("b_out", 32'(b_out), 32'(p_bout));
      chk("zero", 32'(zero), 32'(p_zero));
      chk("ovf", 32'(ovf), 32'(p_ovf));
      if (idle) begin
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 0);
         chk("idle_busy", 32'(busy), 0);
         chk("idle_diff_held", 32'(diff), 32'(p_diff));
      end
   endtask
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      b_in = 1'b0;
      p_diff = '0;
      p_bout = 1'b0;
      p_zero = 1'b0;
      p_ovf = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      op(8'd100, 8'd58, 1'b0, 1'b0, 1'b1);
      op(8'd5, 8'd9, 1'b0, 1'b0, 1'b1);
      op(8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
      op(8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
      op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1);
      op(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
      op(8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0);
      chk("b2b_gap", 32'(gap), W + 1);
      op(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
      chk("b2b_gap2", 32'(gap), W + 1);
      op(8'd200, 8'd13, 1'b0, 1'b1, 1'b1);
      // abandon an operation in flight with an asynchronous reset
      a = 8'h9A;
      b = 8'h17;
      b_in = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("async_rst");
      repeat (2) @(negedge clk);
      chk_zero_outputs("rst_hold");
      rst_n = 1'b1;
      p_diff = '0;
      p_bout = 1'b0;
      p_zero = 1'b0;
      p_ovf = 1'b0;
      @(negedge clk);
      chk_zero_outputs("rst_release");
      op(8'h9A, 8'h17, 1'b1, 1'b0, 1'b1);
      for (int n = 0; n < 24; n++) begin
         op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
